// File: rtl/frame_buffer_mem.sv
// Simple dual-port RGB444 frame buffer: port A writes, port B reads with one cycle of latency, read-first on collision.
// Optional FRAME_BUFFER_CLEAR_EN: zero-fill sweep of the whole array after every reset release, reported on busy.
module frame_buffer_mem #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 17,
  parameter int DEPTH  = 76800
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  input  logic              enb,
  input  logic [ADDR_W-1:0] addrb,
  output logic [DATA_W-1:0] doutb,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  // The array has no reset so that it maps onto block RAM.
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic [DATA_W-1:0] doutb_reg;
  logic              busy_int;
  logic              wa_in_range;
  logic              rb_in_range;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  assign wa_in_range = ({1'b0, addra} < DEPTH_X);
  assign rb_in_range = ({1'b0, addrb} < DEPTH_X);

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam logic [ADDR_W-1:0] SWEEP_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    SW_ARM,
    SW_RUN,
    SW_DONE
  } sweep_state_t;

  sweep_state_t      sweep_state_reg;
  logic [ADDR_W-1:0] sweep_addr_reg;
  logic              busy_reg;

  // Busy rises on the first edge after release; each busy edge then zeroes one word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_state_reg <= SW_ARM;
      sweep_addr_reg  <= '0;
      busy_reg        <= 1'b0;
    end else begin
      case (sweep_state_reg)
        SW_ARM: begin
          busy_reg        <= 1'b1;
          sweep_addr_reg  <= '0;
          sweep_state_reg <= SW_RUN;
        end
        SW_RUN: begin
          if (sweep_addr_reg == SWEEP_LAST) begin
            busy_reg        <= 1'b0;
            sweep_state_reg <= SW_DONE;
          end else begin
            sweep_addr_reg <= sweep_addr_reg + 1'b1;
          end
        end
        default: begin
          busy_reg        <= 1'b0;
          sweep_state_reg <= SW_DONE;
        end
      endcase
    end
  end

  assign busy_int = busy_reg;
`else
  assign busy_int = 1'b0;
`endif

  // Write-port mux; gating with rst_n keeps an in-flight write from landing during reset.
  always_comb begin
    wr_en   = ena & wea & wa_in_range & ~busy_int;
    wr_addr = addra;
    wr_data = dina;
`ifdef FRAME_BUFFER_CLEAR_EN
    if (busy_reg) begin
      wr_en   = 1'b1;
      wr_addr = sweep_addr_reg;
      wr_data = '0;
    end
`endif
    wr_en = wr_en & rst_n;
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Nonblocking read of the array gives read-first behaviour on a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      doutb_reg <= '0;
    end else if (busy_int) begin
      doutb_reg <= '0;
    end else if (enb) begin
      doutb_reg <= rb_in_range ? mem[addrb] : '0;
    end
  end

  assign doutb = doutb_reg;
  assign busy  = busy_int;

endmodule

// File: tb/tb_frame_buffer_mem.sv
// Scoreboard bench for frame_buffer_mem: expected read data is queued when a read is issued and checked a cycle later.
module tb_frame_buffer_mem;

`ifdef FRAME_BUFFER_CLEAR_EN
  localparam int DEPTH = 4096;
`else
  localparam int DEPTH = 76800;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ena;
  logic        wea;
  logic [16:0] addra;
  logic [11:0] dina;
  logic        enb;
  logic [16:0] addrb;
  logic [11:0] doutb;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];
  logic [11:0] model[int];
  bit cleared = 1'b0;

  frame_buffer_mem #(.DATA_W(12), .ADDR_W(17), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .wea(wea), .addra(addra), .dina(dina),
    .enb(enb), .addrb(addrb), .doutb(doutb), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] model_rd(input int a);
    if (a >= DEPTH) return 12'h000;
    if (model.exists(a)) return model[a];
    return cleared ? 12'h000 : 12'hxxx;
  endfunction

  // One clock of stimulus; read expectations are taken before the write lands (read-first).
  task automatic do_cycle(input logic we, input int wa, input logic [11:0] wd,
                          input logic re, input int ra, input string tag);
    logic [11:0] e;
    ena   = we;
    wea   = we;
    addra = wa[16:0];
    dina  = wd;
    enb   = re;
    addrb = ra[16:0];
    if (re) exp_q.push_back(model_rd(ra));
    if (we && wa < DEPTH && busy !== 1'b1) model[wa] = wd;
    @(posedge clk);
    #1;
    ena = 1'b0;
    wea = 1'b0;
    enb = 1'b0;
    if (re) begin
      e = exp_q.pop_front();
      check(tag, {20'd0, doutb}, {20'd0, e});
      $display("rd %s addr=%0d data=%h exp=%h", tag, ra, doutb, e);
    end
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < DEPTH + 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    ena = 1'b0; wea = 1'b0; enb = 1'b0;
    addra = '0; addrb = '0; dina = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_doutb", {20'd0, doutb}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
`ifdef FRAME_BUFFER_CLEAR_EN
    cleared = 1'b1;
`endif
    wait_idle("initial_idle");

    // Boundary addresses.
    do_cycle(1, 0, 12'hA5C, 0, 0, "");
    do_cycle(1, DEPTH - 1, 12'h123, 0, 0, "");
    do_cycle(0, 0, 0, 1, 0, "rd_addr0");
    do_cycle(0, 0, 0, 1, DEPTH - 1, "rd_addr_last");

    // Same-address collision is read-first, new data visible next cycle.
    do_cycle(1, 100, 12'h0F0, 0, 0, "");
    do_cycle(1, 100, 12'hFFF, 1, 100, "collide_old");
    do_cycle(0, 0, 0, 1, 100, "collide_new");

    // Out-of-range write dropped and not aliased; out-of-range read gives 0.
    do_cycle(1, DEPTH, 12'h777, 0, 0, "");
    do_cycle(0, 0, 0, 1, DEPTH, "rd_oob");
    do_cycle(0, 0, 0, 1, 0, "no_alias");

    // doutb holds while enb is low and addrb moves.
    do_cycle(1, 200, 12'h456, 0, 0, "");
    do_cycle(0, 0, 0, 1, 200, "rd_456");
    for (int i = 0; i < 5; i++) begin
      do_cycle(0, 0, 0, 0, i * 7 + 1, "");
      check("hold_456", {20'd0, doutb}, 32'h456);
    end

    // Randomised traffic over a small window, including collisions.
    for (int i = 0; i < 16; i++) do_cycle(1, 1000 + i, 12'($urandom), 0, 0, "");
    for (int i = 0; i < 40; i++) begin
      do_cycle(1'($urandom_range(0, 1)), 1000 + $urandom_range(0, 15), 12'($urandom),
               1'b1, 1000 + $urandom_range(0, 15), "rand_rd");
    end

    // Asynchronous reset mid-stream, with a write held across the reset edge.
    do_cycle(0, 0, 0, 1, 200, "pre_rst_456");
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_doutb", {20'd0, doutb}, 32'd0);
    ena = 1'b1; wea = 1'b1; addra = 17'd0; dina = 12'hBAD;
    @(posedge clk);
    #1;
    ena = 1'b0; wea = 1'b0;
    check("rst_held_doutb", {20'd0, doutb}, 32'd0);
    rst_n = 1'b1;
`ifdef FRAME_BUFFER_CLEAR_EN
    model.delete();
`endif
    wait_idle("post_rst_idle");
    do_cycle(0, 0, 0, 1, 0, "after_rst_addr0");
    do_cycle(0, 0, 0, 1, DEPTH - 1, "after_rst_last");
    do_cycle(0, 0, 0, 1, 200, "after_rst_200");

`ifdef FRAME_BUFFER_CLEAR_EN
    begin
      int cnt;
      do_cycle(1, 5, 12'hABC, 0, 0, "");
      do_cycle(1, 200, 12'h456, 0, 0, "");
      do_cycle(0, 0, 0, 1, 5, "preload_5");
      // Abort a sweep part-way, then measure the full restarted sweep.
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
      #1;
      check("sweep_busy_mid", {31'd0, busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      check("sweep_abort_busy", {31'd0, busy}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model.delete();
      cnt = 0;
      for (int n = 0; n < DEPTH + 20; n++) begin
        if (n == 10) begin
          ena = 1'b1; wea = 1'b1; addra = 17'd5; dina = 12'h111;
          enb = 1'b1; addrb = 17'd200;
        end
        @(posedge clk);
        #1;
        ena = 1'b0; wea = 1'b0; enb = 1'b0;
        if (n == 0) check("sweep_busy_first", {31'd0, busy}, 32'd1);
        if (n == 10) check("sweep_doutb_forced", {20'd0, doutb}, 32'd0);
        if (busy !== 1'b1) break;
        cnt++;
      end
      check("sweep_len", cnt, DEPTH);
      $display("sweep busy cycles=%0d", cnt);
      do_cycle(0, 0, 0, 1, 5, "swept_5");
      do_cycle(0, 0, 0, 1, 200, "swept_200");
    end
`endif

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
